// File: rtl/fpu_pkg.sv
// fpu_pkg -- shared FPU definitions for the fmul issue stage.
//   issue_state_e : IDLE / ISSUE / WAIT sequencing of the multiplier.
//   Float fields  : sign 1, exponent 8, mantissa 23.
//   EXP_ONES      : exponent field of Inf/NaN.
//   FLAG_OVF/UDF  : bit positions inside res_flags ({overflow, underflow}).
package fpu_pkg;
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int FLT_W  = SIGN_W + EXP_W + MAN_W;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  localparam int FLAG_OVF = 1;
  localparam int FLAG_UDF = 0;
  localparam int FLAG_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } issue_state_e;

  function automatic logic [EXP_W-1:0] f_exp(input logic [FLT_W-1:0] f);
    return f[FLT_W-2 -: EXP_W];
  endfunction
endpackage

// File: rtl/fmul_issue_if.sv
// fmul_issue_if -- bundle of the three handshakes around fmul_issue.
//   req_* : dispatch -> issue (valid/ready), operands + tag
//   res_* : issue -> writeback (valid/ready), product + tag (+ flags)
//   mul_* : issue <-> fmul core (start pulse / done pulse)
// Modports: slave = fmul_issue side, master = surrounding FPU side.
// res_flags exists only when FMUL_ISSUE_FLAGS_EN is defined.
interface fmul_issue_if #(parameter int TAG_W = 5);
  import fpu_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [FLT_W-1:0] req_x1;
  logic [FLT_W-1:0] req_x2;
  logic [TAG_W-1:0] req_tag;

  logic             res_valid;
  logic             res_ready;
  logic [FLT_W-1:0] res_y;
  logic [TAG_W-1:0] res_tag;
`ifdef FMUL_ISSUE_FLAGS_EN
  logic [FLAG_W-1:0] res_flags;
`endif

  logic [FLT_W-1:0] mul_x1;
  logic [FLT_W-1:0] mul_x2;
  logic             mul_ready;
  logic             mul_valid;
  logic [FLT_W-1:0] mul_y;

  modport slave (
    input  req_valid, req_x1, req_x2, req_tag,
    output req_ready,
    output res_valid, res_y, res_tag,
`ifdef FMUL_ISSUE_FLAGS_EN
    output res_flags,
`endif
    input  res_ready,
    output mul_x1, mul_x2, mul_ready,
    input  mul_valid, mul_y
  );

  modport master (
    output req_valid, req_x1, req_x2, req_tag,
    input  req_ready,
    input  res_valid, res_y, res_tag,
`ifdef FMUL_ISSUE_FLAGS_EN
    input  res_flags,
`endif
    output res_ready,
    input  mul_x1, mul_x2, mul_ready,
    output mul_valid, mul_y
  );
endinterface

// File: rtl/fmul_req_fifo.sv
// fmul_req_fifo -- small synchronous FIFO holding pending multiply requests.
//   clk, rstn (sync, active low)
//   i_push/i_din : write; ignored while full, even if a pop happens the
//                  same cycle (full is judged on the registered pointers)
//   i_pop/o_dout : read; o_dout shows the head combinationally
//   o_full/o_empty
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fmul_req_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_push, w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/fmul_issue.sv
// fmul_issue -- issue/collect stage in front of the single-precision fmul.
//   clk, rstn (sync, active low)
//   bus (fmul_issue_if.slave):
//     req_*  tagged requests into a QDEPTH-entry queue, req_ready = !full
//     mul_*  operands held in the operand register, one-cycle mul_ready start,
//            product taken on mul_valid
//     res_*  product + tag held in the result register until res_ready
// Optional: define FMUL_ISSUE_FLAGS_EN to add res_flags {overflow, underflow}.
// A new issue only starts once the result register is (or is becoming) free,
// so a capture can never collide with an unread result.
module fmul_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter int QDEPTH = 2
) (
  input logic          clk,
  input logic          rstn,
  fmul_issue_if.slave  bus
);
  localparam int ENT_W = 2*FLT_W + TAG_W;

  issue_state_e     r_state, w_state_nxt;
  logic             w_pop, w_full, w_empty, w_slot_free, w_capture;
  logic [ENT_W-1:0] w_head;
  logic [FLT_W-1:0] r_x1, r_x2, r_y;
  logic [TAG_W-1:0] r_tag, r_res_tag;
  logic             r_res_valid;

  fmul_req_fifo #(.WIDTH(ENT_W), .DEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (bus.req_valid),
    .i_din   ({bus.req_x1, bus.req_x2, bus.req_tag}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.req_ready = !w_full;
  assign w_slot_free   = !r_res_valid || bus.res_ready;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: if (!w_empty && w_slot_free) begin
        w_pop       = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: w_state_nxt = WAIT;
      // fmul always answers; staying here on a missing done is only a guard.
      WAIT: if (bus.mul_valid) begin
        w_capture   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Loaded only on pop, so operands stay frozen through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (!rstn)      {r_x1, r_x2, r_tag} <= '0;
    else if (w_pop) {r_x1, r_x2, r_tag} <= w_head;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_res_valid <= 1'b0;
      r_y         <= '0;
      r_res_tag   <= '0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_y         <= bus.mul_y;
      r_res_tag   <= r_tag;
    end else if (bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

`ifdef FMUL_ISSUE_FLAGS_EN
  logic [FLAG_W-1:0] r_flags;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_flags <= '0;
    end else if (w_capture) begin
      r_flags[FLAG_OVF] <= (f_exp(bus.mul_y) == EXP_ONES);
      r_flags[FLAG_UDF] <= (bus.mul_y[FLT_W-2:0] == '0) &&
                           (f_exp(r_x1) != '0) && (f_exp(r_x2) != '0);
    end
  end

  assign bus.res_flags = r_flags;
`endif

  assign bus.res_valid = r_res_valid;
  assign bus.res_y     = r_y;
  assign bus.res_tag   = r_res_tag;
  assign bus.mul_x1    = r_x1;
  assign bus.mul_x2    = r_x2;
  assign bus.mul_ready = (r_state == ISSUE);
endmodule

// File: tb/tb_fmul_issue.sv
// tb_fmul_issue -- scoreboard bench for fmul_issue with a behavioural fmul.
// Expected products come from real-number arithmetic on the decoded operands.
module tb_fmul_issue;
  localparam int TAG_W  = 5;
  localparam int QDEPTH = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fmul_issue_if #(.TAG_W(TAG_W)) bus ();

  fmul_issue #(.TAG_W(TAG_W), .QDEPTH(QDEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic [1:0]       flags;
  } exp_t;

  exp_t sb[$];
  int   res_cyc_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0, n_res = 0, n_acc = 0, n_mr = 0, mr_cyc = 0;
  logic prev_mr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---- reference arithmetic: decode to real, multiply, re-encode ----
  function automatic real sp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) - 11'd127 + 11'd1023, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    if (e >= 255)          return {d[63], 8'hFF, 23'd0};
    if (e <= 0)            return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] sp_mul(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) * sp2r(b));
  endfunction

  function automatic logic [1:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] y);
    return {y[30:23] == 8'hFF, (y[30:0] == 31'd0) && (a[30:23] != 0) && (b[30:23] != 0)};
  endfunction

  // ---- behavioural fmul: done pulse the cycle after start ----
  initial begin
    logic fire;
    bus.mul_valid = 1'b0;
    bus.mul_y     = 32'h0;
    forever begin
      @(negedge clk);
      fire = bus.mul_ready && rstn;
      @(posedge clk);
      #1;
      bus.mul_valid = fire && rstn;
      // operands read in the done cycle, so drifting operands show up as bad products
      bus.mul_y     = fire ? sp_mul(bus.mul_x1, bus.mul_x2) : 32'h0;
    end
  end

  // ---- start-pulse monitor ----
  initial forever begin
    @(negedge clk);
    if (bus.mul_ready) begin
      check("mul_ready_single", {63'd0, prev_mr}, 64'd0);
      n_mr++;
      mr_cyc = cyc;
    end
    prev_mr = bus.mul_ready;
  end

  // ---- result monitor / scoreboard ----
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected: got y=%0h tag=%0h expected nothing", bus.res_y, bus.res_tag);
        end else begin
          e = sb.pop_front();
          check("res_y", 64'(bus.res_y), 64'(e.y));
          check("res_tag", 64'(bus.res_tag), 64'(e.tag));
`ifdef FMUL_ISSUE_FLAGS_EN
          check("res_flags", 64'(bus.res_flags), 64'(e.flags));
`endif
        end
        n_res++;
        res_cyc_q.push_back(cyc);
      end
    end
  end

  // Called just after a posedge; returns the cycle count seen before the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t, output int acc);
    int   n;
    exp_t e;
    logic [31:0] y;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_x1    = a;
    bus.req_x2    = b;
    bus.req_tag   = t;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    acc = cyc;
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout: req_ready stayed 0 expected 1");
    end else begin
      y = sp_mul(a, b);
      e.y = y; e.tag = t; e.flags = ref_flags(a, b, y);
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_results(input int target, input string name);
    int n;
    n = 0;
    while (n_res < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n_res), 64'(target));
  endtask

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'($urandom_range(70, 185)), 23'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, base, n;
    bit done;
    bus.req_valid = 1'b0;
    bus.req_x1 = '0; bus.req_x2 = '0; bus.req_tag = '0;
    bus.res_ready = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_mul_ready", 64'(bus.mul_ready), 64'd0);
    check("rst_res_y", 64'(bus.res_y), 64'd0);
    check("rst_res_tag", 64'(bus.res_tag), 64'd0);
    check("rst_mul_x1", 64'(bus.mul_x1), 64'd0);
`ifdef FMUL_ISSUE_FLAGS_EN
    check("rst_res_flags", 64'(bus.res_flags), 64'd0);
`endif
    @(posedge clk); #1;

    // ---- single request: 2.0 * 3.0, latency ----
    bus.res_ready = 1'b1;
    send(32'h40000000, 32'h40400000, 5'd3, acc);
    n = 0;
    while (!bus.res_valid && n < 20) begin @(negedge clk); n++; end
    check("single_latency", 64'(cyc - acc), 64'd4);
    check("single_mr_cycle", 64'(mr_cyc - acc), 64'd2);
    wait_results(1, "single_done");

    // ---- back-to-back ----
    res_cyc_q.delete();
    @(posedge clk); #1;
    send(32'h3FC00000, 32'h3FC00000, 5'd1, acc);
    send(32'hC0000000, 32'h3F000000, 5'd2, acc2);
    check("b2b_accept_gap", 64'(acc2 - acc), 64'd1);
    wait_results(3, "b2b_done");
    if (res_cyc_q.size() == 2) check("b2b_spacing", 64'(res_cyc_q[1] - res_cyc_q[0]), 64'd3);
    else check("b2b_res_count", 64'(res_cyc_q.size()), 64'd2);

    // ---- back-pressure + full-queue push/pop same cycle ----
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    n_acc = 0;
    base  = n_res;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(32'h3F800000 + 32'(i << 20), 32'h40000000, 5'(10 + i), acc);
      end
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("bp_res_held", 64'(bus.res_valid), 64'd1);
        check("bp_held_tag", 64'(bus.res_tag), 64'd10);
        check("bp_req_ready_low", 64'(bus.req_ready), 64'd0);
        check("bp_accepted", 64'(n_acc), 64'(1 + QDEPTH));
        check("bp_no_drain", 64'(n_res - base), 64'd0);
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("full_push_refused", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("full_pop_frees_one", 64'(bus.req_ready), 64'd1);
      end
    join
    wait_results(base + 4, "bp_drain_all");

    // ---- zero / overflow / underflow ----
    @(posedge clk); #1;
    send(32'h00000000, 32'h40000000, 5'd4, acc);
    send(32'h7F000000, 32'h7F000000, 5'd5, acc);
    send(32'h00800000, 32'h00800000, 5'd6, acc);
    wait_results(base + 7, "special_done");

    // ---- reset while in WAIT ----
    @(posedge clk); #1;
    base = n_res;
    send(32'h40400000, 32'h40400000, 5'd7, acc);
    send(32'h40800000, 32'h40800000, 5'd8, acc);
    @(posedge clk); #1;
    rstn = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    check("midrst_res_valid", 64'(bus.res_valid), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    check("midrst_mul_ready", 64'(bus.mul_ready), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    n = n_mr;
    repeat (10) @(negedge clk);
    check("midrst_no_stale_res", 64'(n_res), 64'(base));
    check("midrst_no_issue", 64'(n_mr), 64'(n));
    @(posedge clk); #1;
    send(32'h41000000, 32'h3E800000, 5'd9, acc);
    wait_results(base + 1, "midrst_recover");

    // ---- randomized traffic with random writeback stalls ----
    done = 1'b0;
    base = n_res;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send(rnd_f(), rnd_f(), 5'($urandom), acc);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.res_ready = ($urandom_range(0, 3) != 0);
        end
        bus.res_ready = 1'b1;
      end
    join
    wait_results(base + 60, "rand_drain");
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fmul_issue.md
# fmul_issue

Issue/collect stage directly upstream of the single-precision multiplier core `fmul` in the FPU. It accepts tagged multiply requests from the core's FPU dispatch over a valid/ready handshake and buffers them in a small queue. It drives the multiplier's start pulse while holding operands stable, and captures each product with its destination tag into a result register drained by writeback over a second valid/ready handshake.

## Interface
- `TAG_W`, 5: width of the destination register tag.
- `QDEPTH`, 2: request queue depth; must be a power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request offered.
- `req_ready` out 1: queue can accept; equals `!full`.
- `req_x1`, `req_x2` in 32: IEEE-754 single operands.
- `req_tag` in TAG_W: destination tag.
- `res_valid` out 1: result register holds a product.
- `res_ready` in 1: writeback accepts the result.
- `res_y` out 32: product.
- `res_tag` out TAG_W: tag of the product.
- `res_flags` out 2: {overflow, underflow}; present only with `FMUL_ISSUE_FLAGS_EN`.
- `mul_x1`, `mul_x2` out 32: operands to `fmul`, driven from the internal operand register.
- `mul_ready` out 1: one-cycle start pulse to `fmul`.
- `mul_valid` in 1: `fmul` done pulse.
- `mul_y` in 32: `fmul` product, valid only while `mul_valid` is high.

## Operation
- Queue: FIFO of {x1, x2, tag}, `QDEPTH` entries.
  - Push on `req_valid && req_ready`.
  - A push is refused when full, even if a pop happens in the same cycle (no look-through).
- State machine: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when the queue is non-empty and the slot is free. The slot is free when `res_valid` is 0 or `res_ready` is 1 this cycle. On that edge, pop the head into the operand register (x1, x2, tag).
  - ISSUE: `mul_ready` = 1 for exactly this cycle. Next state is WAIT.
  - WAIT: if `mul_valid` is high, load `res_y` ← `mul_y` and `res_tag` ← operand tag, set `res_valid`, and go to IDLE. If `mul_valid` is low, stay in WAIT (defensive).
- The operand register holds its value unchanged from the pop through the WAIT exit. `fmul` requires stable operands until its done cycle.
- `res_valid` clears on `res_valid && res_ready`, unless WAIT captures a new result in the same cycle (cannot occur: the slot was checked at IDLE).
- The product is passed through unmodified: no rounding or special-value handling is added here.

## Timing
- Reset values: state IDLE; queue empty; `res_valid` 0; `mul_ready` 0; operand register 0; `res_y`/`res_tag`/`res_flags` 0; `req_ready` 1 in the first cycle after reset.
- Latency with an empty queue and free slot:
  - request accepted at edge t;
  - pop at t+1;
  - `mul_ready` high in cycle t+1..t+2;
  - `mul_valid` and capture at t+3;
  - `res_valid` high from t+3.
- Throughput: one product per 3 cycles. `fmul` cannot accept a new start in its done cycle.
- Back-pressure: if `res_ready` stays low, no new issue occurs. The queue fills, then `req_ready` drops.
- `rstn` low mid-operation: all state is discarded at the next edge, including an in-flight product. The `fmul` core is reset by the same `rstn`.

## Configuration
- `FMUL_ISSUE_FLAGS_EN` defined:
  - `res_flags` exists and is registered with `res_y`.
  - Overflow = `mul_y[30:23]` == 8'hFF.
  - Underflow = `mul_y[30:0]` == 0 while both operand exponent fields are non-zero.
- Not defined:
  - port and logic are absent;
  - all other behaviour is identical.

## Structure
- Shared package `fpu_pkg`:
  - state enum (IDLE/ISSUE/WAIT);
  - float field widths (sign 1, exponent 8, mantissa 23);
  - exponent-all-ones constant;
  - flag bit indices.
- Sub-module `fmul_req_fifo`: parameterised width/depth FIFO with full/empty and wrap-around pointers (one extra pointer bit distinguishes full from empty).

## Test plan
- Single request: x1 0x40000000, x2 0x40400000, tag 3 → `res_y` 0x40C00000, `res_tag` 3, `res_valid` rises 3 cycles after acceptance; `mul_ready` is a single cycle.
- Back-to-back: 1.5×1.5 (0x3FC00000) tag 1, then −2×0.5 (0xC0000000 × 0x3F000000) tag 2, with `res_ready` held at 1 → 0x40100000/1 then 0xBF800000/2, in order, 3 cycles apart.
- Back-pressure: `res_ready` = 0 and 4 requests offered → the first result is held; `req_ready` falls after QDEPTH queued. Releasing `res_ready` drains all results in order, with no loss or duplication.
- Zero and flags: 0x00000000 × 0x40000000 → 0x00000000, flags 00. 0x7F000000 × 0x7F000000 → 0x7F800000, flags 10. 0x00800000 × 0x00800000 → 0x00000000, flags 01 (flags cases only with `FMUL_ISSUE_FLAGS_EN`).
- Reset mid-flight: assert `rstn` = 0 in WAIT → next cycle `res_valid` 0, queue empty, `req_ready` 1, state IDLE; no stale result appears afterwards.
- Full-queue push + pop same cycle: push is refused (`req_ready` 0); the queue count after the edge is QDEPTH−1.
